encoder8to3_pend: RTL and testbench



---
 rtl/decoder_pkg.sv | 7 +
 rtl/prio_enc8.sv | 29 ++
 rtl/encoder8to3_pend.sv | 73 +++++++
 tb/tb_encoder8to3_pend.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared constants and code type for the 3-to-8 decoder / 8-to-3 encoder pair.
// No logic: parameters and types only.
package decoder_pkg;
  localparam int LINES  = 8;
  localparam int CODE_W = 3;
  typedef logic [CODE_W-1:0] code_t;
endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-line priority encoder: index of winning set bit plus any-set flag.
// Zero latency, no handshake; HIGH_FIRST picks highest (1) or lowest (0) index.
module prio_enc8
  import decoder_pkg::*;
#(
  parameter int HIGH_FIRST = 1
) (
  input  logic [LINES-1:0] i_vec,
  output code_t            o_idx,
  output logic             o_any
);

  always_comb begin
    o_idx = '0;
    if (HIGH_FIRST != 0) begin
      // Ascending scan: the last hit is the highest set index.
      for (int i = 0; i < LINES; i++) begin
        if (i_vec[i]) o_idx = CODE_W'(i);
      end
    end else begin
      for (int i = LINES - 1; i >= 0; i--) begin
        if (i_vec[i]) o_idx = CODE_W'(i);
      end
    end
  end

  assign o_any = |i_vec;

endmodule

// File: rtl/encoder8to3_pend.sv
// Sticky-pending 8-to-3 encoder: strobe to code in 2 edges, one code per cycle.
// valid/ready output; while stalled A holds and new strobes keep accumulating.
module encoder8to3_pend
  import decoder_pkg::*;
#(
  parameter int HIGH_FIRST = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  input  logic D4,
  input  logic D5,
  input  logic D6,
  input  logic D7,
  input  logic ready,
  output logic A2,
  output logic A1,
  output logic A0,
  output logic valid,
  output logic busy
);

  logic [LINES-1:0] r_pending;
  code_t            r_code;
  logic             r_valid;

  logic [LINES-1:0] w_d;
  logic [LINES-1:0] w_taken;
  code_t            w_idx;
  logic             w_any;
  logic             w_load;

  assign w_d = {D7, D6, D5, D4, D3, D2, D1, D0};

  // Selection looks only at the registered pending set, never at live D.
  prio_enc8 #(
    .HIGH_FIRST (HIGH_FIRST)
  ) u_prio (
    .i_vec (r_pending),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_load  = (!r_valid || ready) && w_any;
  assign w_taken = w_load ? (LINES'(1) << w_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_code    <= '0;
      r_valid   <= 1'b0;
    end else begin
      // OR-ing D after the clear lets a re-strobe on the load edge survive.
      r_pending <= (r_pending & ~w_taken) | w_d;
      if (w_load) begin
        r_code  <= w_idx;
        r_valid <= 1'b1;
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign A2    = r_code[2];
  assign A1    = r_code[1];
  assign A0    = r_code[0];
  assign valid = r_valid;
  assign busy  = r_valid || (|r_pending);

endmodule

// File: tb/tb_encoder8to3_pend.sv
// Scoreboard bench: two instances (HIGH_FIRST 1 and 0) against a set-based reference model.
module tb_encoder8to3_pend;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d = 8'h00;
  logic       ready = 1'b0;

  logic a2h, a1h, a0h, vh, bh;
  logic a2l, a1l, a0l, vl, bl;

  int checks = 0;
  int failures = 0;

  // Reference state: set of waiting lines, whether a code is on the output.
  bit m_set   [2][8];
  bit m_valid [2];
  int exp_q0[$];
  int exp_q1[$];
  int acc_q0[$];
  int acc_q1[$];

  always #5 clk = ~clk;

  encoder8to3_pend #(.HIGH_FIRST(1)) dut_hi (
    .clk(clk), .rst_n(rst_n),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .D4(d[4]), .D5(d[5]), .D6(d[6]), .D7(d[7]),
    .ready(ready), .A2(a2h), .A1(a1h), .A0(a0h), .valid(vh), .busy(bh)
  );

  encoder8to3_pend #(.HIGH_FIRST(0)) dut_lo (
    .clk(clk), .rst_n(rst_n),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .D4(d[4]), .D5(d[5]), .D6(d[6]), .D7(d[7]),
    .ready(ready), .A2(a2l), .A1(a1l), .A0(a0l), .valid(vl), .busy(bl)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit set_empty(input int n);
    for (int i = 0; i < 8; i++) if (m_set[n][i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int set_mask(input int n);
    int m = 0;
    for (int i = 0; i < 8; i++) if (m_set[n][i]) m += (1 << i);
    return m;
  endfunction

  // n==0 serves the highest waiting line first, n==1 the lowest.
  function automatic int pick(input int n);
    int best = -1;
    for (int i = 0; i < 8; i++) begin
      if (m_set[n][i]) begin
        if (n == 0) best = i;
        else if (best < 0) best = i;
      end
    end
    return best;
  endfunction

  task automatic model_clear();
    for (int n = 0; n < 2; n++) begin
      m_valid[n] = 1'b0;
      for (int i = 0; i < 8; i++) m_set[n][i] = 1'b0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Applies one clock edge to the model using the inputs present at that edge.
  task automatic model_edge();
    int c;
    if (!rst_n) begin
      model_clear();
      return;
    end
    for (int n = 0; n < 2; n++) begin
      if ((!m_valid[n] || ready) && !set_empty(n)) begin
        c = pick(n);
        m_set[n][c] = 1'b0;
        m_valid[n] = 1'b1;
        if (n == 0) exp_q0.push_back(c);
        else exp_q1.push_back(c);
      end else if (m_valid[n] && ready) begin
        m_valid[n] = 1'b0;
      end
      for (int i = 0; i < 8; i++) if (d[i]) m_set[n][i] = 1'b1;
    end
  endtask

  task automatic step(input logic [7:0] dv, input logic rdy);
    d = dv;
    ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Monitor: outputs are stable at the falling edge; an accept happens at the next rise.
  always @(negedge clk) begin
    int ah, al;
    ah = {a2h, a1h, a0h};
    al = {a2l, a1l, a0l};
    chk("hi_valid", int'(vh), int'(exp_q0.size() != 0));
    chk("hi_busy", int'(bh), int'(m_valid[0] || !set_empty(0)));
    if (vh && exp_q0.size() != 0) begin
      chk("hi_code", ah, exp_q0[0]);
      if (ready) begin
        void'(exp_q0.pop_front());
        acc_q0.push_back(ah);
      end
    end
    chk("lo_valid", int'(vl), int'(exp_q1.size() != 0));
    chk("lo_busy", int'(bl), int'(m_valid[1] || !set_empty(1)));
    if (vl && exp_q1.size() != 0) begin
      chk("lo_code", al, exp_q1[0]);
      if (ready) begin
        void'(exp_q1.pop_front());
        acc_q1.push_back(al);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 1'b1);
  endtask

  initial begin
    logic [7:0] rv;
    model_clear();
    #2;
    chk("reset_A", int'({a2h, a1h, a0h}), 0);
    chk("reset_valid", int'(vh), 0);
    chk("reset_busy", int'(bh), 0);
    step(8'h00, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // Reset while a code is stalled on the output.
    step(8'h20, 1'b0);
    step(8'h00, 1'b0);
    chk("stall_valid", int'(vh), 1);
    chk("stall_A", int'({a2h, a1h, a0h}), 5);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("rst_mid_A", int'({a2h, a1h, a0h}), 0);
    chk("rst_mid_valid", int'(vh), 0);
    chk("rst_mid_busy", int'(bh), 0);
    step(8'h00, 1'b0);
    rst_n = 1'b1;
    idle(4);

    // Single strobe: code two edges after the sample, gone one edge later.
    step(8'h08, 1'b1);
    step(8'h00, 1'b1);
    chk("single_valid", int'(vh), 1);
    chk("single_A", int'({a2h, a1h, a0h}), 3);
    step(8'h00, 1'b1);
    chk("single_drop", int'(vh), 0);
    chk("single_busy", int'(bh), 0);

    // Simultaneous burst drains in priority order, one per cycle.
    acc_q0.delete();
    acc_q1.delete();
    step(8'h52, 1'b1);
    idle(5);
    chk("burst_cnt_hi", acc_q0.size(), 3);
    chk("burst_cnt_lo", acc_q1.size(), 3);
    if (acc_q0.size() == 3 && acc_q1.size() == 3) begin
      chk("burst_hi_0", acc_q0[0], 6);
      chk("burst_hi_1", acc_q0[1], 4);
      chk("burst_hi_2", acc_q0[2], 1);
      chk("burst_lo_0", acc_q1[0], 1);
      chk("burst_lo_1", acc_q1[1], 4);
      chk("burst_lo_2", acc_q1[2], 6);
    end

    // Backpressure: 7 held while 2 waits in pending.
    acc_q0.delete();
    step(8'h80, 1'b0);
    step(8'h04, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(8'h00, 1'b0);
      chk("bp_valid", int'(vh), 1);
      chk("bp_A", int'({a2h, a1h, a0h}), 7);
      chk("bp_pending", int'(dut_hi.r_pending), 8'h04);
    end
    idle(4);
    chk("bp_cnt", acc_q0.size(), 2);
    if (acc_q0.size() == 2) begin
      chk("bp_first", acc_q0[0], 7);
      chk("bp_second", acc_q0[1], 2);
    end

    // Re-request of line 6 on its own load edge.
    acc_q0.delete();
    step(8'h40, 1'b1);
    step(8'h40, 1'b1);
    step(8'h00, 1'b1);
    chk("rereq_busy_mid", int'(bh), 1);
    step(8'h00, 1'b1);
    chk("rereq_busy_end", int'(bh), 0);
    idle(2);
    chk("rereq_cnt", acc_q0.size(), 2);
    if (acc_q0.size() == 2) begin
      chk("rereq_a", acc_q0[0], 6);
      chk("rereq_b", acc_q0[1], 6);
    end

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      rv = 8'($urandom) & 8'($urandom) & 8'($urandom);
      step(rv, ($urandom_range(0, 3) != 0));
    end
    idle(20);
    chk("drain_q_hi", exp_q0.size(), 0);
    chk("drain_q_lo", exp_q1.size(), 0);
    chk("drain_busy_hi", int'(bh), 0);
    chk("drain_busy_lo", int'(bl), 0);
    chk("drain_set", set_mask(0) | set_mask(1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
